// File: rtl/memory_access_stage_pkg.sv
// rtl/memory_access_stage_pkg.sv - shared control-word layout, encodings and FSM states for the memory stage
package memory_access_stage_pkg;

  localparam int CW_W         = 14;
  localparam int CW_BRANCH    = 13;
  localparam int CW_RF_WB     = 12;
  localparam int CW_MEM_WE    = 11;
  localparam int CW_WB_SRC_HI = 10;
  localparam int CW_WB_SRC_LO = 9;
  localparam int CW_PC_SRC    = 8;
  localparam int CW_RD_HI     = 7;
  localparam int CW_RD_LO     = 3;
  localparam int CW_F3_HI     = 2;
  localparam int CW_F3_LO     = 0;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'b00,
    WB_SRC_MEM = 2'b01
  } wb_src_e;

  // funct3[1:0] selects the access size for both loads and stores
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-enable / store-lane replication and load extraction / extension
module load_store_align
  import memory_access_stage_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_sdata;
    case (i_funct3[1:0])
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_sdata[7:0]}};
      end
      SZ_HALF: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_sdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_sdata;
      end
    endcase
  end

  always_comb begin
    o_ldata = w_shifted;
    case (i_funct3)
      F3_LB:   o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  o_ldata = {24'd0, w_shifted[7:0]};
      F3_LHU:  o_ldata = {16'd0, w_shifted[15:0]};
      F3_LW:   o_ldata = w_shifted;
      default: o_ldata = w_shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - pipeline memory stage: req/gnt/rvalid data bus, load align, writeback register
// Optional build macro MISALIGN_TRAP_EN turns misaligned half/word accesses into bus-free trapped completions.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_ex,
  input  logic              done_ex,
  input  logic              flush_mem,
  input  logic [CW_W-1:0]   control_word_ex,
  input  logic [31:0]       calculated_adr,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       regfileb_ex,
  output logic              stall_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              valid_mem,
  output logic              rf_wb_mem,
  output logic [4:0]        rd_mem,
  output logic [31:0]       wb_data_mem,
  output logic              misaligned_mem
);

  mem_state_e  r_state;
  mem_state_e  w_next_state;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_alu;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_is_load;
  logic        r_killed;
  logic        r_valid_mem;
  logic        r_rf_wb_mem;
  logic        r_misaligned_mem;
  logic [4:0]  r_rd_mem;
  logic [31:0] r_wb_data_mem;

  logic        w_idle;
  logic        w_rf_wb;
  logic        w_is_store;
  logic        w_is_load;
  logic        w_misalign;
  logic        w_accept;
  logic        w_mem_op;
  logic        w_done_store;
  logic        w_done_load;
  logic        w_kill;
  logic [31:0] w_addr;
  logic [31:0] w_sdata;
  logic [31:0] w_alu;
  logic [31:0] w_ldata;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_unused;

  // branch_taken and pc_src are consumed by fetch
  assign w_unused = ^{control_word_ex[CW_BRANCH], control_word_ex[CW_PC_SRC]};

  assign w_idle     = (r_state == ST_IDLE);
  assign w_rf_wb    = control_word_ex[CW_RF_WB];
  assign w_is_store = control_word_ex[CW_MEM_WE];
  assign w_is_load  = ~w_is_store & w_rf_wb &
                      (control_word_ex[CW_WB_SRC_HI:CW_WB_SRC_LO] == WB_SRC_MEM);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = (w_is_store | w_is_load) &
                      (((control_word_ex[1:0] == SZ_HALF) & calculated_adr[0]) |
                       ((control_word_ex[1:0] == SZ_WORD) & (calculated_adr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = rst & w_idle & valid_ex & done_ex & ~flush_mem;
  assign w_mem_op = w_accept & (w_is_store | w_is_load) & ~w_misalign;

  // In IDLE the bus sees the live execute inputs; afterwards only the captured copy
  assign w_addr   = w_idle ? calculated_adr : r_addr;
  assign w_sdata  = w_idle ? regfileb_ex : r_sdata;
  assign w_alu    = w_idle ? ALU_result : r_alu;
  assign w_funct3 = w_idle ? control_word_ex[CW_F3_HI:CW_F3_LO] : r_funct3;
  assign w_rd     = w_idle ? control_word_ex[CW_RD_HI:CW_RD_LO] : r_rd;

  load_store_align u_align (
    .i_addr_lo (w_addr[1:0]),
    .i_funct3  (w_funct3),
    .i_sdata   (w_sdata),
    .i_rdata   (dmem_rdata),
    .o_be      (dmem_be),
    .o_wdata   (dmem_wdata),
    .o_ldata   (w_ldata)
  );

  assign dmem_addr = {w_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_next_state = r_state;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    stall_mem    = 1'b0;
    w_done_store = 1'b0;
    w_done_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          dmem_req = 1'b1;
          dmem_we  = w_is_store;
          if (dmem_gnt) begin
            w_next_state = w_is_store ? ST_IDLE : ST_RESP;
            w_done_store = w_is_store;
          end else begin
            w_next_state = ST_REQ;
            stall_mem    = 1'b1;
          end
        end
      end
      ST_REQ: begin
        dmem_req  = 1'b1;
        dmem_we   = ~r_is_load;
        stall_mem = 1'b1;
        if (dmem_gnt) begin
          w_next_state = r_is_load ? ST_RESP : ST_IDLE;
          w_done_store = ~r_is_load;
        end
      end
      ST_RESP: begin
        stall_mem = 1'b1;
        if (dmem_rvalid) begin
          w_next_state = ST_IDLE;
          w_done_load  = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // A flush seen while the bus transaction is in flight only suppresses writeback
  assign w_kill = ~w_idle & (r_killed | flush_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_addr           <= 32'd0;
      r_sdata          <= 32'd0;
      r_alu            <= 32'd0;
      r_funct3         <= 3'd0;
      r_rd             <= 5'd0;
      r_is_load        <= 1'b0;
      r_killed         <= 1'b0;
      r_valid_mem      <= 1'b0;
      r_rf_wb_mem      <= 1'b0;
      r_misaligned_mem <= 1'b0;
      r_rd_mem         <= 5'd0;
      r_wb_data_mem    <= 32'd0;
    end else begin
      r_state          <= w_next_state;
      r_valid_mem      <= 1'b0;
      r_rf_wb_mem      <= 1'b0;
      r_misaligned_mem <= 1'b0;
      if (w_mem_op) begin
        r_addr    <= calculated_adr;
        r_sdata   <= regfileb_ex;
        r_alu     <= ALU_result;
        r_funct3  <= control_word_ex[CW_F3_HI:CW_F3_LO];
        r_rd      <= control_word_ex[CW_RD_HI:CW_RD_LO];
        r_is_load <= w_is_load;
        r_killed  <= 1'b0;
      end else if (!w_idle) begin
        r_killed <= r_killed | flush_mem;
      end
      if (w_accept && !w_mem_op) begin
        r_valid_mem      <= 1'b1;
        r_rf_wb_mem      <= w_rf_wb & ~w_misalign;
        r_rd_mem         <= control_word_ex[CW_RD_HI:CW_RD_LO];
        r_wb_data_mem    <= ALU_result;
        r_misaligned_mem <= w_misalign;
      end else if ((w_done_store || w_done_load) && !w_kill) begin
        r_valid_mem   <= 1'b1;
        r_rf_wb_mem   <= w_done_load;
        r_rd_mem      <= w_rd;
        r_wb_data_mem <= w_done_load ? w_ldata : w_alu;
      end
    end
  end

  assign valid_mem      = r_valid_mem;
  assign rf_wb_mem      = r_rf_wb_mem;
  assign rd_mem         = r_rd_mem;
  assign wb_data_mem    = r_wb_data_mem;
  assign misaligned_mem = r_misaligned_mem;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - scoreboard bench for memory_access_stage with directed vectors
module tb_memory_access_stage;

  logic        clk;
  logic        rst;
  logic        valid_ex;
  logic        done_ex;
  logic        flush_mem;
  logic [13:0] control_word_ex;
  logic [31:0] calculated_adr;
  logic [31:0] ALU_result;
  logic [31:0] regfileb_ex;
  logic        stall_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        valid_mem;
  logic        rf_wb_mem;
  logic [4:0]  rd_mem;
  logic [31:0] wb_data_mem;
  logic        misaligned_mem;

  typedef struct packed {
    logic        mis;
    logic        rf;
    logic [4:0]  rd;
    logic [31:0] wb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  memory_access_stage #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_ex        (valid_ex),
    .done_ex         (done_ex),
    .flush_mem       (flush_mem),
    .control_word_ex (control_word_ex),
    .calculated_adr  (calculated_adr),
    .ALU_result      (ALU_result),
    .regfileb_ex     (regfileb_ex),
    .stall_mem       (stall_mem),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_be         (dmem_be),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .valid_mem       (valid_mem),
    .rf_wb_mem       (rf_wb_mem),
    .rd_mem          (rd_mem),
    .wb_data_mem     (wb_data_mem),
    .misaligned_mem  (misaligned_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] cw(input logic br, input logic rf, input logic we,
                                     input logic [1:0] src, input logic pcs,
                                     input logic [4:0] rd, input logic [2:0] f3);
    return {br, rf, we, src, pcs, rd, f3};
  endfunction

  // Monitor: every writeback pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst && valid_mem) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=rd%0d/%h required=no_writeback", rd_mem, wb_data_mem);
      end else begin
        e = q.pop_front();
        checks++;
        if (rf_wb_mem !== e.rf || rd_mem !== e.rd || misaligned_mem !== e.mis ||
            (e.rf && wb_data_mem !== e.wb)) begin
          errors++;
          $display("FAIL sb_writeback actual=rf%0b rd%0d mis%0b %h required=rf%0b rd%0d mis%0b %h",
                   rf_wb_mem, rd_mem, misaligned_mem, wb_data_mem, e.rf, e.rd, e.mis, e.wb);
        end
      end
    end
  end

  // Starts at a drive point in the low clock phase, ends at the drive point of the cycle after completion
  task automatic issue(input string nm, input logic [13:0] cwd, input logic [31:0] adr,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rdat,
                       input int gw, input int rw, input bit fl, input bit mis,
                       input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] ewb,
                       input int est);
    bit   st;
    bit   ld;
    bit   mem;
    int   stalls;
    exp_t e;
    st     = cwd[11];
    ld     = !st && cwd[12] && (cwd[10:9] == 2'b01);
    mem    = (st || ld) && !mis;
    stalls = 0;
    valid_ex        = 1'b1;
    done_ex         = 1'b1;
    flush_mem       = 1'b0;
    control_word_ex = cwd;
    calculated_adr  = adr;
    ALU_result      = alu;
    regfileb_ex     = sd;
    if (!fl) begin
      e.mis = mis;
      e.rf  = mis ? 1'b0 : (ld || (!st && cwd[12]));
      e.rd  = cwd[7:3];
      e.wb  = ld ? ewb : alu;
      q.push_back(e);
    end
    if (!mem) begin
      dmem_gnt = 1'b0;
      #1;
      chk({nm, "_noreq"}, dmem_req, 0);
      chk({nm, "_nostall"}, stall_mem, 0);
      @(negedge clk);
      valid_ex = 1'b0;
      #1;
      chk({nm, "_latency"}, valid_mem, 1);
    end else begin
      for (int w = 0; w <= gw; w++) begin
        dmem_gnt = (w == gw);
        #1;
        chk({nm, "_req"}, dmem_req, 1);
        chk({nm, "_we"}, dmem_we, st);
        chk({nm, "_be"}, dmem_be, ebe);
        chk({nm, "_addr"}, dmem_addr, {adr[31:2], 2'b00});
        if (st) chk({nm, "_wdata"}, dmem_wdata, ewd);
        if (stall_mem) stalls++;
        @(negedge clk);
        if (w == 0) begin
          valid_ex        = 1'b0;
          control_word_ex = 14'h3fff;
          calculated_adr  = $urandom;
          regfileb_ex     = $urandom;
          ALU_result      = $urandom;
        end
      end
      dmem_gnt = 1'b0;
      if (ld) begin
        for (int w = 0; w <= rw; w++) begin
          dmem_rvalid = (w == rw);
          dmem_rdata  = (w == rw) ? rdat : 32'hDEAD_BEEF;
          flush_mem   = fl && (w == 0);
          #1;
          chk({nm, "_resp_noreq"}, dmem_req, 0);
          if (stall_mem) stalls++;
          @(negedge clk);
        end
      end
      dmem_rvalid = 1'b0;
      flush_mem   = 1'b0;
      #1;
      chk({nm, "_latency"}, valid_mem, !fl);
      chk({nm, "_stall_cycles"}, stalls, est);
    end
  endtask

  initial begin
    rst             = 1'b0;
    valid_ex        = 1'b0;
    done_ex         = 1'b0;
    flush_mem       = 1'b0;
    control_word_ex = 14'd0;
    calculated_adr  = 32'd0;
    ALU_result      = 32'd0;
    regfileb_ex     = 32'd0;
    dmem_gnt        = 1'b0;
    dmem_rvalid     = 1'b0;
    dmem_rdata      = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", valid_mem, 0);
    chk("rst_rf_wb", rf_wb_mem, 0);
    chk("rst_rd", rd_mem, 0);
    chk("rst_wb", wb_data_mem, 0);
    chk("rst_mis", misaligned_mem, 0);
    chk("rst_req", dmem_req, 0);
    @(negedge clk);
    rst = 1'b1;

    // name, cw, addr, alu, store data, rdata, gnt wait, rvalid wait, flush, mis, be, wdata, wb, stalls
    issue("pass", cw(1, 1, 0, 2'b00, 1, 5'd5, 3'd0), 32'h0, 32'h0000_1234, 32'h0, 32'h0,
          0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    issue("pass_norf", cw(0, 0, 0, 2'b10, 0, 5'd9, 3'd2), 32'h4, 32'h0000_0777, 32'h0, 32'h0,
          0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    issue("sw", cw(0, 0, 1, 2'b00, 0, 5'd0, 3'b010), 32'h200, 32'h0, 32'hCAFE_BABE, 32'h0,
          0, 0, 0, 0, 4'b1111, 32'hCAFE_BABE, 32'h0, 0);
    issue("sb", cw(0, 0, 1, 2'b00, 0, 5'd0, 3'b000), 32'h103, 32'h0, 32'h1234_56AB, 32'h0,
          1, 0, 0, 0, 4'b1000, 32'hABAB_ABAB, 32'h0, 2);
    issue("sh", cw(0, 0, 1, 2'b00, 0, 5'd0, 3'b001), 32'h102, 32'h0, 32'h0000_BEEF, 32'h0,
          0, 0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0);
    issue("lb", cw(0, 1, 0, 2'b01, 0, 5'd10, 3'b000), 32'h101, 32'h0, 32'h0, 32'h0000_F000,
          0, 0, 0, 0, 4'b0010, 32'h0, 32'hFFFF_FFF0, 1);
    issue("lhu", cw(0, 1, 0, 2'b01, 0, 5'd11, 3'b101), 32'h102, 32'h0, 32'h0, 32'h8000_0000,
          1, 2, 0, 0, 4'b1100, 32'h0, 32'h0000_8000, 5);
    issue("lh", cw(0, 1, 0, 2'b01, 0, 5'd12, 3'b001), 32'h100, 32'h0, 32'h0, 32'h0000_8001,
          0, 0, 0, 0, 4'b0011, 32'h0, 32'hFFFF_8001, 1);
    issue("lbu", cw(0, 1, 0, 2'b01, 0, 5'd13, 3'b100), 32'h103, 32'h0, 32'h0, 32'h9A00_0000,
          0, 0, 0, 0, 4'b1000, 32'h0, 32'h0000_009A, 1);
    issue("lw", cw(0, 1, 0, 2'b01, 0, 5'd14, 3'b010), 32'h104, 32'h0, 32'h0, 32'h89AB_CDEF,
          0, 0, 0, 0, 4'b1111, 32'h0, 32'h89AB_CDEF, 1);
    issue("flush_resp", cw(0, 1, 0, 2'b01, 0, 5'd15, 3'b010), 32'h108, 32'h0, 32'h0, 32'h1111_2222,
          0, 1, 1, 0, 4'b1111, 32'h0, 32'h0, 2);
    issue("b2b_pass", cw(0, 1, 0, 2'b00, 0, 5'd7, 3'd0), 32'h0, 32'h0000_55AA, 32'h0, 32'h0,
          0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    issue("lw_misalign", cw(0, 1, 0, 2'b01, 0, 5'd4, 3'b010), 32'h102, 32'h0, 32'h0, 32'h0,
          0, 0, 0, 1, 4'h0, 32'h0, 32'h0, 0);
`else
    issue("lw_unaligned", cw(0, 1, 0, 2'b01, 0, 5'd4, 3'b010), 32'h102, 32'h0, 32'h0, 32'h1234_5678,
          0, 0, 0, 0, 4'b1111, 32'h0, 32'h0000_1234, 1);
`endif
    issue("pass_pre_rst", cw(0, 1, 0, 2'b00, 0, 5'd7, 3'd0), 32'h0, 32'h0000_55AA, 32'h0, 32'h0,
          0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Reset while a load waits for grant in REQ
    valid_ex        = 1'b1;
    done_ex         = 1'b1;
    control_word_ex = cw(0, 1, 0, 2'b01, 0, 5'd3, 3'b010);
    calculated_adr  = 32'h10C;
    dmem_gnt        = 1'b0;
    #1;
    chk("rstreq_issue", dmem_req, 1);
    @(negedge clk);
    valid_ex = 1'b0;
    #1;
    chk("rstreq_hold", dmem_req, 1);
    rst = 1'b0;
    #1;
    chk("rstreq_req", dmem_req, 0);
    chk("rstreq_stall", stall_mem, 0);
    chk("rstreq_valid", valid_mem, 0);
    chk("rstreq_rd", rd_mem, 0);
    chk("rstreq_wb", wb_data_mem, 0);
    @(negedge clk);
    rst = 1'b1;
    issue("lw_after_rst", cw(0, 1, 0, 2'b01, 0, 5'd21, 3'b010), 32'h110, 32'h0, 32'h0, 32'h0BAD_F00D,
          2, 0, 0, 0, 4'b1111, 32'h0, 32'h0BAD_F00D, 4);

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
